fitness_arbiter: RTL and testbench
==================================

FITNESS_ARBITER -- requirements
Module: fitness_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 2, giving the number of requesters (range 2..8).
REQ-002 The module SHALL have parameter IND_W, default 25, giving the individual width in bits.
REQ-003 The module SHALL have parameter FIT_W, default 16, giving the fitness width in bits.
REQ-004 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before abort.
REQ-005 Ports SHALL be: clk, in, 1, the single clock; all state updates on its rising edge.
REQ-006 Ports SHALL be: rst, in, 1, reset, asynchronous and active-high.
REQ-007 Ports SHALL be: req, in, NUM_REQ, per-requester request level.
REQ-008 Ports SHALL be: ind_in, in, NUM_REQ*IND_W, individual for requester i in bits [i*IND_W +: IND_W].
REQ-009 Ports SHALL be: ack, out, NUM_REQ, one-cycle completion pulse for requester i.
REQ-010 Ports SHALL be: fit_out, out, FIT_W, fitness result, broadcast to all requesters.
REQ-011 Ports SHALL be: fu_start, out, 1, one-cycle start pulse to the shared fitness unit.
REQ-012 Ports SHALL be: fu_ind, out, IND_W, individual presented to the fitness unit.
REQ-013 Ports SHALL be: fu_done, in, 1, fitness unit completion pulse.
REQ-014 Ports SHALL be: fu_fitness, in, FIT_W, fitness value, valid only while fu_done is high.
REQ-015 Ports SHALL be: busy, out, 1, high whenever the state is not IDLE.
REQ-016 Ports SHALL be: grant_id, out, 3, index of the requester currently or last granted.
REQ-017 Ports SHALL be: timeout_err, out, 1, sticky flag set on a fitness unit timeout.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with req nonzero, the block SHALL select the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-020 On the transition out of IDLE, the block SHALL latch grant_id and fu_ind = ind_in slice of the winner, then enter ISSUE.
REQ-021 fu_ind SHALL hold constant from ISSUE through RESP.
REQ-022 In ISSUE, fu_start SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT; fu_start SHALL be 0 in all other states.
REQ-023 fu_done SHALL be sampled only in WAIT; fu_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-024 In WAIT with fu_done=1, the block SHALL latch fit_out = fu_fitness and enter RESP.
REQ-025 In WAIT, a cycle counter SHALL increment each cycle; when it reaches TIMEOUT without fu_done, the block SHALL set timeout_err, set fit_out = 0 and enter RESP.
REQ-026 If fu_done and the timeout occur in the same cycle, fu_done SHALL win and timeout_err SHALL NOT be set.
REQ-027 In RESP, ack[grant_id] SHALL be 1 for exactly one cycle, last_grant SHALL be updated to grant_id, and the FSM SHALL return to IDLE; all other ack bits SHALL be 0.
REQ-028 fit_out SHALL hold its value until the next RESP.
REQ-029 A requester that drops req after being granted SHALL NOT abort the transaction; the transaction SHALL complete and ack SHALL still pulse.
REQ-030 Latency SHALL be as follows: with req sampled in IDLE in cycle 0, fu_start occurs in cycle 1; with fu_done in cycle n ≥ 2, ack occurs in cycle n+1 and IDLE in cycle n+2.
REQ-031 Each requester SHALL hold req until it sees ack, then deassert req in the following cycle; a req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-032 timeout_err SHALL clear only on rst.

Reset
REQ-033 While rst is high, the block SHALL force: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), grant_id=0, fu_ind=0, fit_out=0, ack=0, fu_start=0, busy=0, timeout_err=0, counter=0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no ack, and any later fu_done SHALL be ignored.

Verification
REQ-035 Single request: req=01, ind_in[0]=0x0ABCDEF, fu_done returned 3 cycles after fu_start with fu_fitness=0x1234 -> fu_ind=0x0ABCDEF, ack=01 for one cycle, fit_out=0x1234, busy back to 0.
REQ-036 Contention: req=11 held, each requester deasserts after its ack and reasserts once -> grants alternate 0,1,0,1 and no requester is starved.
REQ-037 Timeout with TIMEOUT=4 and fu_done never asserted -> ack pulses after 4 WAIT cycles, fit_out=0, timeout_err=1 and remains 1 across later successful transactions.
REQ-038 Spurious done: fu_done=1 in the ISSUE cycle and again 2 cycles later with 0x00FF -> the first is ignored and fit_out=0x00FF.
REQ-039 Reset mid-WAIT with rst pulsed for 1 cycle -> no ack, busy=0 immediately, a subsequent fu_done is ignored, and the next req=10 is granted to requester 1 (last_grant reset value 1 puts requester 0 first only when it is requesting).
REQ-040 Boundary: fu_done and the timeout in the same cycle -> fit_out=fu_fitness and timeout_err stays 0.

Source files
------------

// File: rtl/fitness_arbiter.sv
// fitness_arbiter: round-robin arbiter that shares one fitness unit among
// NUM_REQ requesters. A granted individual is issued to the unit, the result
// (or a timeout) is captured and broadcast, and the winner receives an ack pulse.
module fitness_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IND_W   = 25,
  parameter int FIT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IND_W-1:0] ind_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic [FIT_W-1:0]         fit_out,
  output logic                     fu_start,
  output logic [IND_W-1:0]         fu_ind,
  input  logic                     fu_done,
  input  logic [FIT_W-1:0]         fu_fitness,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [2:0]       last_grant;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       winner;
  logic [IND_W-1:0] winner_ind;

  // Round-robin search: first requester strictly after the last grant, wrapping.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [2:0]         last);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && 1'(r >> idx)) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner     = rr_pick(req, last_grant);
  assign winner_ind = IND_W'(ind_in >> (int'(winner) * IND_W));

  // Arbitration FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 3'(NUM_REQ - 1);
      grant_id    <= '0;
      fu_ind      <= '0;
      fit_out     <= '0;
      ack         <= '0;
      fu_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      fu_start <= 1'b0;
      ack      <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= winner;
            fu_ind   <= winner_ind;
            fu_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (fu_done) begin
            fit_out <= fu_fitness;
            ack     <= ONE_HOT0 << grant_id;
            state   <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt         <= cnt + 1'b1;
            timeout_err <= 1'b1;
            fit_out     <= '0;
            ack         <= ONE_HOT0 << grant_id;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_arbiter.sv
// tb_fitness_arbiter: transaction-level reference model of the arbiter driven
// with directed scenarios followed by randomized transactions.
module tb_fitness_arbiter;

  localparam int NUM_REQ = 3;
  localparam int IND_W   = 25;
  localparam int FIT_W   = 16;
  localparam int TIMEOUT = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TOT_W   = NUM_REQ * IND_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_REQ-1:0] req = '0;
  logic [TOT_W-1:0]   ind_in = '0;
  logic [NUM_REQ-1:0] ack;
  logic [FIT_W-1:0]   fit_out;
  logic               fu_start;
  logic [IND_W-1:0]   fu_ind;
  logic               fu_done = 1'b0;
  logic [FIT_W-1:0]   fu_fitness = '0;
  logic               busy;
  logic [2:0]         grant_id;
  logic               timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int               m_last;
  logic [FIT_W-1:0] m_fit;
  logic             m_terr;
  logic [IND_W-1:0] ind_arr [NUM_REQ];

  fitness_arbiter #(
    .NUM_REQ(NUM_REQ), .IND_W(IND_W), .FIT_W(FIT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ind_in(ind_in), .ack(ack),
    .fit_out(fit_out), .fu_start(fu_start), .fu_ind(fu_ind),
    .fu_done(fu_done), .fu_fitness(fu_fitness), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (r[IDX_W'(c)]) return c;
    end
    return 0;
  endfunction

  task automatic set_inds(input bit fix, input int slot, input logic [IND_W-1:0] v);
    ind_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ind_arr[IDX_W'(i)] = (fix && i == slot) ? v : IND_W'($urandom);
      ind_in = ind_in | (TOT_W'(ind_arr[IDX_W'(i)]) << (i * IND_W));
    end
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      fu_done    = 1'($urandom);
      fu_fitness = FIT_W'($urandom);
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_start", 64'(fu_start), 64'd0);
      chk("idle_ack", 64'(ack), 64'd0);
      chk("idle_fit", 64'(fit_out), 64'(m_fit));
    end
    fu_done = 1'b0;
  endtask

  // One transaction. d = WAIT cycle (1-based) in which fu_done is returned;
  // 0 or anything beyond TIMEOUT means the unit never answers.
  task automatic txn(input logic [NUM_REQ-1:0] r, input int d, input logic [FIT_W-1:0] fit,
                     input bit spur, input bit drop, input bit fix, input logic [IND_W-1:0] fixv);
    int                 win;
    int                 wend;
    bit                 tmo;
    logic [IND_W-1:0]   exp_ind;
    logic [NUM_REQ-1:0] exp_ack;
    win = pick(r, m_last);
    set_inds(fix, win, fixv);
    exp_ind = ind_arr[IDX_W'(win)];
    req     = r;
    fu_done = 1'b0;
    @(negedge clk);
    chk("issue_start", 64'(fu_start), 64'd1);
    chk("issue_busy", 64'(busy), 64'd1);
    chk("issue_grant", 64'(grant_id), 64'(win));
    chk("issue_fu_ind", 64'(fu_ind), 64'(exp_ind));
    chk("issue_ack", 64'(ack), 64'd0);
    if (drop) req[IDX_W'(win)] = 1'b0;
    set_inds(1'b0, 0, '0);
    fu_done    = spur;
    fu_fitness = FIT_W'($urandom);
    tmo  = !(d >= 1 && d <= TIMEOUT);
    wend = tmo ? TIMEOUT : d;
    for (int w = 1; w <= wend; w++) begin
      @(negedge clk);
      chk("wait_start", 64'(fu_start), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_ack", 64'(ack), 64'd0);
      chk("wait_fu_ind", 64'(fu_ind), 64'(exp_ind));
      fu_done    = (w == d);
      fu_fitness = (w == d) ? fit : FIT_W'($urandom);
    end
    if (tmo) begin
      m_fit  = '0;
      m_terr = 1'b1;
    end else begin
      m_fit = fit;
    end
    @(negedge clk);
    exp_ack = '0;
    exp_ack[IDX_W'(win)] = 1'b1;
    chk("resp_ack", 64'(ack), 64'(exp_ack));
    chk("resp_fit", 64'(fit_out), 64'(m_fit));
    chk("resp_terr", 64'(timeout_err), 64'(m_terr));
    chk("resp_busy", 64'(busy), 64'd1);
    chk("resp_start", 64'(fu_start), 64'd0);
    chk("resp_fu_ind", 64'(fu_ind), 64'(exp_ind));
    chk("resp_grant", 64'(grant_id), 64'(win));
    fu_done    = 1'($urandom);
    fu_fitness = FIT_W'($urandom);
    req[IDX_W'(win)] = 1'b0;
    @(negedge clk);
    fu_done = 1'b0;
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_ack", 64'(ack), 64'd0);
    chk("post_start", 64'(fu_start), 64'd0);
    chk("post_fit", 64'(fit_out), 64'(m_fit));
    chk("post_terr", 64'(timeout_err), 64'(m_terr));
    m_last = win;
  endtask

  // Start a transaction, pulse reset k cycles into WAIT, then offer a stray done.
  task automatic reset_mid(input logic [NUM_REQ-1:0] r, input int k);
    int win;
    win = pick(r, m_last);
    set_inds(1'b0, 0, '0);
    req     = r;
    fu_done = 1'b0;
    @(negedge clk);
    chk("rm_grant", 64'(grant_id), 64'(win));
    for (int w = 1; w <= k; w++) @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_ack", 64'(ack), 64'd0);
    chk("rm_start", 64'(fu_start), 64'd0);
    chk("rm_fit", 64'(fit_out), 64'd0);
    chk("rm_terr", 64'(timeout_err), 64'd0);
    chk("rm_fu_ind", 64'(fu_ind), 64'd0);
    chk("rm_grant0", 64'(grant_id), 64'd0);
    m_last = NUM_REQ - 1;
    m_fit  = '0;
    m_terr = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    fu_done    = 1'b1;
    fu_fitness = FIT_W'($urandom);
    @(negedge clk);
    fu_done = 1'b0;
    chk("rm_after_busy", 64'(busy), 64'd0);
    chk("rm_after_ack", 64'(ack), 64'd0);
    chk("rm_after_fit", 64'(fit_out), 64'd0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] r;
    int sel;
    m_last = NUM_REQ - 1;
    m_fit  = '0;
    m_terr = 1'b0;

    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_start", 64'(fu_start), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_fu_ind", 64'(fu_ind), 64'd0);
    chk("rst_fit", 64'(fit_out), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Single request with a fixed individual
    txn(3'b001, 3, 16'h1234, 1'b0, 1'b0, 1'b1, 25'h0ABCDEF);
    // Done on the same cycle as the timeout: success, no error flag
    txn(3'b010, TIMEOUT, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0);
    // Spurious done in ISSUE, real one two cycles later
    txn(3'b001, 2, 16'h00FF, 1'b1, 1'b0, 1'b0, '0);
    // Timeout, then a successful transaction keeps the sticky flag
    txn(3'b100, 0, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0);
    txn(3'b001, 1, 16'h5A5A, 1'b0, 1'b1, 1'b0, '0);
    idle_cycles(1);
    // Reset in the middle of WAIT, then requester 1 alone
    reset_mid(3'b001, 2);
    txn(3'b010, 3, 16'h0F0F, 1'b0, 1'b0, 1'b0, '0);
    // Contention between requesters 0 and 1
    for (int i = 0; i < 4; i++)
      txn(3'b011, $urandom_range(3, 1), FIT_W'($urandom), 1'b0, 1'b0, 1'b0, '0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(7, 0);
      r   = NUM_REQ'($urandom_range((1 << NUM_REQ) - 1, 1));
      if (sel == 0)
        reset_mid(r, $urandom_range(TIMEOUT - 1, 1));
      else if (sel == 1)
        idle_cycles($urandom_range(3, 1));
      else
        txn(r, $urandom_range(TIMEOUT + 2, 0), FIT_W'($urandom),
            1'($urandom), 1'($urandom), 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
